// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//   Multi-lane branch resolver at the end of execute. Each cycle it resolves the
//   oldest valid control-flow instruction across ISSUE_NUM lanes, compares it with
//   the front-end prediction, tracks the MIPS delay slot, drives the wrong-path
//   kill mask, and holds a registered redirect request for fetch (valid/ready).
//   A one-cycle predictor update pulse follows every branch resolved in IDLE.
//   Optional build macro: BRANCH_LIKELY_EN. When it is defined, a not-taken
//   "likely" branch (op[4]=1) nullifies its delay slot.
module branch_resolve_unit #(
    parameter int ISSUE_NUM = 2,
    parameter int ADDR_W    = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic [ISSUE_NUM-1:0]        lane_valid,
    input  logic [5*ISSUE_NUM-1:0]      lane_op,
    input  logic [32*ISSUE_NUM-1:0]     lane_reg0,
    input  logic [32*ISSUE_NUM-1:0]     lane_reg1,
    input  logic [ADDR_W*ISSUE_NUM-1:0] lane_pc,
    input  logic [ADDR_W*ISSUE_NUM-1:0] lane_target_i,
    input  logic [ADDR_W*ISSUE_NUM-1:0] lane_target_j,
    input  logic [ISSUE_NUM-1:0]        lane_pred_taken,
    input  logic [ADDR_W*ISSUE_NUM-1:0] lane_pred_target,
    output logic [ISSUE_NUM-1:0]        kill_mask,
    output logic                        redirect_valid,
    output logic [ADDR_W-1:0]           redirect_pc,
    input  logic                        redirect_ready,
    output logic                        upd_valid,
    output logic [ADDR_W-1:0]           upd_pc,
    output logic [ADDR_W-1:0]           upd_target,
    output logic                        upd_taken,
    output logic                        busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_DS  = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                redirect_valid_q, redirect_valid_d;
    logic [ADDR_W-1:0]   redirect_pc_q, redirect_pc_d;
    logic                pend_q, pend_d;   // WAIT_DS ends in a redirect
    logic                null_q, null_d;   // WAIT_DS must nullify lane 0
    logic                upd_valid_q, upd_valid_d;
    logic [ADDR_W-1:0]   upd_pc_q, upd_pc_d;
    logic [ADDR_W-1:0]   upd_target_q, upd_target_d;
    logic                upd_taken_q, upd_taken_d;
    logic                busy_q, busy_d;

    logic                found_s;
    int                  k_s;
    logic [4:0]          op_s;
    logic [31:0]         reg0_s, reg1_s;
    logic [ADDR_W-1:0]   pc_s, tgt_i_s, tgt_j_s, pred_tgt_s;
    logic                pred_taken_s;
    logic                ds_valid_s;
    logic                eq_s, neg_s, taken_s, likely_s, mispredict_s;
    logic [ADDR_W-1:0]   target_s, correct_pc_s;
    logic [ISSUE_NUM-1:0] kill_s;

    // Pick the oldest valid lane holding a branch op and check whether its delay slot is in the same bundle
    always_comb begin
        found_s      = 1'b0;
        k_s          = 0;
        op_s         = 5'd0;
        reg0_s       = 32'd0;
        reg1_s       = 32'd0;
        pc_s         = {ADDR_W{1'b0}};
        tgt_i_s      = {ADDR_W{1'b0}};
        tgt_j_s      = {ADDR_W{1'b0}};
        pred_tgt_s   = {ADDR_W{1'b0}};
        pred_taken_s = 1'b0;
        ds_valid_s   = 1'b0;
        for (int i = 0; i < ISSUE_NUM; i++) begin
            if (!found_s && lane_valid[i] && (lane_op[5*i +: 4] != 4'd0) && (lane_op[5*i +: 4] <= 4'd12)) begin
                found_s      = 1'b1;
                k_s          = i;
                op_s         = lane_op[5*i +: 5];
                reg0_s       = lane_reg0[32*i +: 32];
                reg1_s       = lane_reg1[32*i +: 32];
                pc_s         = lane_pc[ADDR_W*i +: ADDR_W];
                tgt_i_s      = lane_target_i[ADDR_W*i +: ADDR_W];
                tgt_j_s      = lane_target_j[ADDR_W*i +: ADDR_W];
                pred_tgt_s   = lane_pred_target[ADDR_W*i +: ADDR_W];
                pred_taken_s = lane_pred_taken[i];
            end else begin
                found_s = found_s;
            end
        end
        for (int i = 0; i < ISSUE_NUM; i++) begin
            if (i == k_s + 1) begin
                ds_valid_s = lane_valid[i];
            end else begin
                ds_valid_s = ds_valid_s;
            end
        end
    end

    // Decode direction and target of the selected branch and compare with the prediction
    always_comb begin
        eq_s     = (reg0_s == reg1_s);
        neg_s    = reg0_s[31];
        taken_s  = 1'b0;
        target_s = tgt_i_s;
        case (op_s[3:0])
            4'd1:         taken_s = eq_s;
            4'd2:         taken_s = !eq_s;
            4'd3:         taken_s = eq_s | neg_s;
            4'd4:         taken_s = !eq_s & !neg_s;
            4'd5, 4'd7:   taken_s = neg_s;
            4'd6, 4'd8:   taken_s = !neg_s;
            4'd9, 4'd10: begin
                taken_s  = 1'b1;
                target_s = tgt_j_s;
            end
            4'd11, 4'd12: begin
                taken_s  = 1'b1;
                target_s = reg0_s[ADDR_W-1:0];
            end
            default:      taken_s = 1'b0;
        endcase
        correct_pc_s = taken_s ? target_s : (pc_s + {{(ADDR_W-4){1'b0}}, 4'd8});
`ifdef BRANCH_LIKELY_EN
        likely_s = found_s & op_s[4] & !taken_s;
`else
        likely_s = 1'b0;
`endif
        mispredict_s = found_s & ((taken_s != pred_taken_s) | (taken_s & (target_s != pred_tgt_s)));
    end

    // Next state, kill mask and next values for the registered outputs
    always_comb begin
        state_d       = state_q;
        kill_s        = {ISSUE_NUM{1'b0}};
        redirect_pc_d = redirect_pc_q;
        pend_d        = pend_q;
        null_d        = null_q;
        upd_valid_d   = 1'b0;
        upd_pc_d      = upd_pc_q;
        upd_target_d  = upd_target_q;
        upd_taken_d   = upd_taken_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found_s) begin
                        upd_valid_d  = 1'b1;
                        upd_pc_d     = pc_s;
                        upd_target_d = target_s;
                        upd_taken_d  = taken_s;
                    end else begin
                        upd_valid_d  = 1'b0;
                    end
                    if (mispredict_s) begin
                        redirect_pc_d = correct_pc_s;
                        if (ds_valid_s) begin
                            // delay slot is in this bundle: it survives unless nullified
                            state_d = REDIRECT;
                            for (int i = 0; i < ISSUE_NUM; i++) begin
                                kill_s[i] = (i > k_s + 1) || (likely_s && (i == k_s + 1));
                            end
                        end else begin
                            state_d = WAIT_DS;
                            pend_d  = 1'b1;
                            null_d  = likely_s;
                            for (int i = 0; i < ISSUE_NUM; i++) begin
                                kill_s[i] = (i > k_s);
                            end
                        end
                    end else if (likely_s) begin
                        // correctly predicted not-taken likely branch: only the slot dies
                        if (ds_valid_s) begin
                            for (int i = 0; i < ISSUE_NUM; i++) begin
                                kill_s[i] = (i == k_s + 1);
                            end
                        end else begin
                            state_d = WAIT_DS;
                            pend_d  = 1'b0;
                            null_d  = 1'b1;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                WAIT_DS: begin
                    if (lane_valid[0]) begin
                        for (int i = 0; i < ISSUE_NUM; i++) begin
                            kill_s[i] = (i == 0) ? null_q : pend_q;
                        end
                        state_d = pend_q ? REDIRECT : IDLE;
                    end else begin
                        state_d = WAIT_DS;
                    end
                end
                REDIRECT: begin
                    kill_s = {ISSUE_NUM{1'b1}};
                    if (redirect_ready) begin
                        state_d = IDLE;
                    end else begin
                        state_d = REDIRECT;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        redirect_valid_d = (state_d == REDIRECT);
        busy_d           = (state_d != IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= {ADDR_W{1'b0}};
            pend_q           <= 1'b0;
            null_q           <= 1'b0;
            upd_valid_q      <= 1'b0;
            upd_pc_q         <= {ADDR_W{1'b0}};
            upd_target_q     <= {ADDR_W{1'b0}};
            upd_taken_q      <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            pend_q           <= pend_d;
            null_q           <= null_d;
            upd_valid_q      <= upd_valid_d;
            upd_pc_q         <= upd_pc_d;
            upd_target_q     <= upd_target_d;
            upd_taken_q      <= upd_taken_d;
            busy_q           <= busy_d;
        end
    end

    assign kill_mask      = kill_s;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign upd_valid      = upd_valid_q;
    assign upd_pc         = upd_pc_q;
    assign upd_target     = upd_target_q;
    assign upd_taken      = upd_taken_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed vectors with literal expectations plus a
// behavioural model checked against the DUT on every clock cycle after reset.
module tb_branch_resolve_unit;
    localparam int N  = 2;
    localparam int AW = 32;
`ifdef BRANCH_LIKELY_EN
    localparam bit LIKELY_EN = 1'b1;
`else
    localparam bit LIKELY_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic [N-1:0]    lane_valid;
    logic [5*N-1:0]  lane_op;
    logic [32*N-1:0] lane_reg0, lane_reg1;
    logic [AW*N-1:0] lane_pc, lane_target_i, lane_target_j, lane_pred_target;
    logic [N-1:0]    lane_pred_taken;
    logic [N-1:0]    kill_mask;
    logic            redirect_valid, redirect_ready, upd_valid, upd_taken, busy;
    logic [AW-1:0]   redirect_pc, upd_pc, upd_target;

    int n_checks = 0;
    int n_fail   = 0;

    branch_resolve_unit #(.ISSUE_NUM(N), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .lane_valid(lane_valid), .lane_op(lane_op),
        .lane_reg0(lane_reg0), .lane_reg1(lane_reg1), .lane_pc(lane_pc),
        .lane_target_i(lane_target_i), .lane_target_j(lane_target_j),
        .lane_pred_taken(lane_pred_taken), .lane_pred_target(lane_pred_target),
        .kill_mask(kill_mask), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready), .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_target(upd_target), .upd_taken(upd_taken), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_mode;            // 0 idle, 1 awaiting delay slot, 2 redirect held
    logic        m_pend, m_null;
    logic [31:0] m_rpc;
    logic        e_uv, e_ut;
    logic [31:0] e_upc, e_utgt;
    logic [N-1:0] c_kill;
    int          c_mode;
    logic        c_pend, c_null, c_res, c_tk;
    logic [31:0] c_rpc, c_pc, c_tgt;

    function automatic logic br_taken(input int code, input logic [31:0] a, input logic [31:0] b);
        case (code)
            1:              return a == b;
            2:              return a != b;
            3:              return (a == b) || ($signed(a) < 0);
            4:              return (a != b) && ($signed(a) >= 0);
            5, 7:           return $signed(a) < 0;
            6, 8:           return $signed(a) >= 0;
            9, 10, 11, 12:  return 1'b1;
            default:        return 1'b0;
        endcase
    endfunction

    task automatic model_eval();
        int k;
        int code;
        logic tk, mis, likely, ds_here;
        logic [31:0] tgt, cpc, r0, r1, pc;
        c_kill = '0; c_mode = m_mode; c_pend = m_pend; c_null = m_null; c_rpc = m_rpc;
        c_res = 1'b0; c_tk = 1'b0; c_pc = 32'd0; c_tgt = 32'd0;
        if (flush) begin
            c_mode = 0;
        end else if (m_mode == 0) begin
            k = -1;
            for (int i = N - 1; i >= 0; i--) begin
                code = int'(lane_op[5*i +: 4]);
                if (lane_valid[i] && code >= 1 && code <= 12) k = i;
            end
            if (k >= 0) begin
                code = int'(lane_op[5*k +: 4]);
                r0 = lane_reg0[32*k +: 32];
                r1 = lane_reg1[32*k +: 32];
                pc = lane_pc[AW*k +: AW];
                tk = br_taken(code, r0, r1);
                if (code == 9 || code == 10) tgt = lane_target_j[AW*k +: AW];
                else if (code >= 11)         tgt = r0;
                else                         tgt = lane_target_i[AW*k +: AW];
                cpc = tk ? tgt : pc + 32'd8;
                likely  = LIKELY_EN && lane_op[5*k + 4] && !tk;
                mis     = (tk != lane_pred_taken[k]) || (tk && tgt != lane_pred_target[AW*k +: AW]);
                ds_here = (k + 1 < N) && lane_valid[k+1];
                c_res = 1'b1; c_tk = tk; c_pc = pc; c_tgt = tgt;
                if (mis) begin
                    c_rpc = cpc;
                    if (ds_here) begin
                        c_mode = 2;
                        for (int i = k + 2; i < N; i++) c_kill[i] = 1'b1;
                        if (likely) c_kill[k+1] = 1'b1;
                    end else begin
                        c_mode = 1; c_pend = 1'b1; c_null = likely;
                        for (int i = k + 1; i < N; i++) c_kill[i] = 1'b1;
                    end
                end else if (likely) begin
                    if (ds_here) c_kill[k+1] = 1'b1;
                    else begin c_mode = 1; c_pend = 1'b0; c_null = 1'b1; end
                end
            end
        end else if (m_mode == 1) begin
            if (lane_valid[0]) begin
                c_kill    = {N{m_pend}};
                c_kill[0] = m_null;
                c_mode    = m_pend ? 2 : 0;
            end
        end else begin
            c_kill = '1;
            if (redirect_ready) c_mode = 0;
        end
    endtask

    // model state advances on the same edge as the DUT
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0; m_pend = 1'b0; m_null = 1'b0; m_rpc = 32'd0;
            e_uv = 1'b0; e_ut = 1'b0; e_upc = 32'd0; e_utgt = 32'd0;
        end else begin
            model_eval();
            m_mode = c_mode; m_pend = c_pend; m_null = c_null; m_rpc = c_rpc;
            e_uv = c_res;
            if (c_res) begin e_upc = c_pc; e_utgt = c_tgt; e_ut = c_tk; end
        end
    end

    // compare every cycle, away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            model_eval();
            check("kill_mask", 32'(kill_mask), 32'(c_kill));
            check("redirect_valid", 32'(redirect_valid), 32'(m_mode == 2));
            check("busy", 32'(busy), 32'(m_mode != 0));
            check("redirect_pc", redirect_pc, m_rpc);
            check("upd_valid", 32'(upd_valid), 32'(e_uv));
            if (e_uv) begin
                check("upd_pc", upd_pc, e_upc);
                check("upd_target", upd_target, e_utgt);
                check("upd_taken", 32'(upd_taken), 32'(e_ut));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_lanes();
        lane_valid = '0; lane_op = '0; lane_reg0 = '0; lane_reg1 = '0; lane_pc = '0;
        lane_target_i = '0; lane_target_j = '0; lane_pred_taken = '0; lane_pred_target = '0;
    endtask

    task automatic set_lane(input int i, input logic [4:0] op, input logic [31:0] r0, input logic [31:0] r1,
                            input logic [31:0] pc, input logic [31:0] ti, input logic [31:0] tj,
                            input logic pt, input logic [31:0] ptg);
        lane_valid[i] = 1'b1;
        lane_op[5*i +: 5] = op;
        lane_reg0[32*i +: 32] = r0;
        lane_reg1[32*i +: 32] = r1;
        lane_pc[AW*i +: AW] = pc;
        lane_target_i[AW*i +: AW] = ti;
        lane_target_j[AW*i +: AW] = tj;
        lane_pred_taken[i] = pt;
        lane_pred_target[AW*i +: AW] = ptg;
    endtask

    task automatic settle(); @(negedge clk); #1; endtask
    task automatic adv();    @(posedge clk); #1; endtask
    task automatic accept(); redirect_ready = 1'b1; adv(); redirect_ready = 1'b0; endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; redirect_ready = 1'b0;
        clear_lanes();
        #1;
        check("reset redirect_valid", 32'(redirect_valid), 32'd0);
        check("reset redirect_pc", redirect_pc, 32'd0);
        check("reset upd_valid", 32'(upd_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset kill_mask", 32'(kill_mask), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // 1: BEQ taken, correctly predicted
        set_lane(0, 5'd1, 32'd5, 32'd5, 32'h100, 32'h400, 32'h0, 1'b1, 32'h400);
        settle(); check("t1 kill", 32'(kill_mask), 32'd0);
        adv(); clear_lanes();
        settle();
        check("t1 upd_valid", 32'(upd_valid), 32'd1);
        check("t1 upd_taken", 32'(upd_taken), 32'd1);
        check("t1 upd_target", upd_target, 32'h400);
        check("t1 redirect_valid", 32'(redirect_valid), 32'd0);

        // 2: BNE mispredicted, delay slot in lane 1, redirect held 3 cycles
        adv();
        set_lane(0, 5'd2, 32'd7, 32'd7, 32'hBFC00010, 32'hBFC00100, 32'h0, 1'b1, 32'hBFC00100);
        set_lane(1, 5'd0, 32'd0, 32'd0, 32'hBFC00014, 32'h0, 32'h0, 1'b0, 32'h0);
        settle(); check("t2 kill", 32'(kill_mask), 32'd0);
        adv(); clear_lanes();
        settle();
        check("t2 redirect_valid", 32'(redirect_valid), 32'd1);
        check("t2 redirect_pc", redirect_pc, 32'hBFC00018);
        check("t2 upd_taken", 32'(upd_taken), 32'd0);
        for (int j = 0; j < 3; j++) begin
            adv();
            set_lane(0, 5'd1, 32'd1, 32'd1, 32'h300, 32'h0, 32'h0, 1'b0, 32'h0);
            set_lane(1, 5'd0, 32'd0, 32'd0, 32'h304, 32'h0, 32'h0, 1'b0, 32'h0);
            settle();
            check("t2 hold pc", redirect_pc, 32'hBFC00018);
            check("t2 hold kill", 32'(kill_mask), 32'd3);
        end
        adv(); clear_lanes(); redirect_ready = 1'b1;
        settle(); check("t2 accept kill", 32'(kill_mask), 32'd3);
        adv(); redirect_ready = 1'b0;
        settle();
        check("t2 idle rv", 32'(redirect_valid), 32'd0);
        check("t2 idle busy", 32'(busy), 32'd0);

        // 3: JR in lane 1 mispredicted -> wait for delay slot in lane 0
        adv();
        set_lane(0, 5'd0, 32'd0, 32'd0, 32'h500, 32'h0, 32'h0, 1'b0, 32'h0);
        set_lane(1, 5'd11, 32'h80001234, 32'd0, 32'h504, 32'h0, 32'h0, 1'b0, 32'h0);
        settle(); check("t3 kill", 32'(kill_mask), 32'd0);
        adv(); clear_lanes();
        set_lane(1, 5'd1, 32'd3, 32'd3, 32'h600, 32'h700, 32'h0, 1'b0, 32'h0);
        settle();
        check("t3 wait kill", 32'(kill_mask), 32'd0);
        check("t3 wait busy", 32'(busy), 32'd1);
        check("t3 upd_target", upd_target, 32'h80001234);
        adv(); clear_lanes();
        set_lane(0, 5'd0, 32'd0, 32'd0, 32'h50C, 32'h0, 32'h0, 1'b0, 32'h0);
        set_lane(1, 5'd0, 32'd0, 32'd0, 32'h510, 32'h0, 32'h0, 1'b0, 32'h0);
        settle(); check("t3 ds kill", 32'(kill_mask), 32'd2);
        adv(); clear_lanes();
        settle();
        check("t3 redirect_valid", 32'(redirect_valid), 32'd1);
        check("t3 redirect_pc", redirect_pc, 32'h80001234);
        accept();

        // 4: flush during REDIRECT with ready low
        set_lane(0, 5'd2, 32'd9, 32'd9, 32'h800, 32'h900, 32'h0, 1'b1, 32'h900);
        set_lane(1, 5'd0, 32'd0, 32'd0, 32'h804, 32'h0, 32'h0, 1'b0, 32'h0);
        settle();
        adv(); clear_lanes();
        settle(); check("t4 pre rv", 32'(redirect_valid), 32'd1);
        adv(); flush = 1'b1;
        settle(); check("t4 flush kill", 32'(kill_mask), 32'd0);
        adv(); flush = 1'b0;
        settle();
        check("t4 rv", 32'(redirect_valid), 32'd0);
        check("t4 busy", 32'(busy), 32'd0);

        // 5a: BLTZ taken, target mispredicted
        adv();
        set_lane(0, 5'd5, 32'h80000000, 32'd0, 32'hFFFFFFF8, 32'h1000, 32'h0, 1'b1, 32'h2000);
        set_lane(1, 5'd0, 32'd0, 32'd0, 32'hFFFFFFFC, 32'h0, 32'h0, 1'b0, 32'h0);
        settle();
        adv(); clear_lanes();
        settle();
        check("t5a redirect_pc", redirect_pc, 32'h1000);
        check("t5a upd_taken", 32'(upd_taken), 32'd1);
        accept();
        // 5b: same branch not taken -> fall-through wraps to zero
        set_lane(0, 5'd5, 32'h00000001, 32'd0, 32'hFFFFFFF8, 32'h1000, 32'h0, 1'b1, 32'h2000);
        set_lane(1, 5'd0, 32'd0, 32'd0, 32'hFFFFFFFC, 32'h0, 32'h0, 1'b0, 32'h0);
        settle();
        adv(); clear_lanes();
        settle();
        check("t5b redirect_pc", redirect_pc, 32'h00000000);
        check("t5b redirect_valid", 32'(redirect_valid), 32'd1);
        accept();

        // 6: BEQL not taken, correctly predicted, delay slot in lane 1
        set_lane(0, 5'b10001, 32'd1, 32'd2, 32'hA00, 32'hB00, 32'h0, 1'b0, 32'h0);
        set_lane(1, 5'd0, 32'd0, 32'd0, 32'hA04, 32'h0, 32'h0, 1'b0, 32'h0);
        settle(); check("t6 kill", 32'(kill_mask), LIKELY_EN ? 32'd2 : 32'd0);
        adv(); clear_lanes();
        settle();
        check("t6 rv", 32'(redirect_valid), 32'd0);
        check("t6 busy", 32'(busy), 32'd0);

        // 7: younger mispredicting J in lane 1 is ignored
        adv();
        set_lane(0, 5'd1, 32'd1, 32'd2, 32'hC00, 32'hD00, 32'h0, 1'b0, 32'h0);
        set_lane(1, 5'd9, 32'd0, 32'd0, 32'hC04, 32'h0, 32'h5000, 1'b0, 32'h0);
        settle(); check("t7 kill", 32'(kill_mask), 32'd0);
        adv(); clear_lanes();
        settle();
        check("t7 upd_pc", upd_pc, 32'hC00);
        check("t7 rv", 32'(redirect_valid), 32'd0);

        // 8: flush in IDLE suppresses resolution
        adv(); flush = 1'b1;
        set_lane(0, 5'd2, 32'd4, 32'd4, 32'hE00, 32'hF00, 32'h0, 1'b1, 32'hF00);
        settle(); check("t8 kill", 32'(kill_mask), 32'd0);
        adv(); flush = 1'b0; clear_lanes();
        settle();
        check("t8 upd_valid", 32'(upd_valid), 32'd0);
        check("t8 busy", 32'(busy), 32'd0);

        adv();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
